// File: rtl/teleport_pkg.sv
// Shared definitions for the teleportation emulator: Alice-side FSM states,
// measurement outcome encoding shared with the correction stage, and the
// 16-bit LFSR polynomial used to draw random measurement outcomes.
package teleport_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CNOT = 3'd2,
    ST_HAD  = 3'd3,
    ST_MEAS = 3'd4,
    ST_HOLD = 3'd5
  } alice_state_t;

  // Outcome encoding {q0,q1}: bit 0 requests X on Bob, bit 1 requests Z.
  localparam logic [1:0] M00 = 2'b00;
  localparam logic [1:0] M01 = 2'b01;
  localparam logic [1:0] M10 = 2'b10;
  localparam logic [1:0] M11 = 2'b11;

  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: the feedback
  // bit is the XOR of state bits 0, 2, 3 and 5 and enters at bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // One LFSR step.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = ^(s & LFSR_TAPS);
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR. An all-zero seed would lock the
// register up, so it is replaced by 16'h0001.
module lfsr16
  import teleport_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  localparam logic [15:0] RESET_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR value, computed every cycle regardless of any other state.
  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= RESET_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/alice_measurement.sv
// Alice's half of quantum teleportation on a 3-qubit real-amplitude state
// vector (index {q0,q1,q2}, q0 = message qubit, q2 = Bob's qubit). Gates are
// unnormalised so every entry is exactly +-alpha, +-beta or 0; entries carry
// one extra bit so that -2^(WIDTH-1) survives the Hadamard without overflow.
module alice_measurement
  import teleport_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] alpha,
  input  logic [WIDTH-1:0] beta,
  input  logic             meas_override_en,
  input  logic [1:0]       meas_override,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       meas_bits,
  output logic [WIDTH-1:0] bob_alpha,
  output logic [WIDTH-1:0] bob_beta
);

  alice_state_t state_q, state_d;

  logic [WIDTH-1:0]        alpha_q, alpha_d;
  logic [WIDTH-1:0]        beta_q, beta_d;
  logic signed [WIDTH:0]   sv_q [8];
  logic signed [WIDTH:0]   sv_d [8];
  logic                    busy_q, busy_d;
  logic                    out_valid_q, out_valid_d;
  logic [1:0]              meas_bits_q, meas_bits_d;
  logic [WIDTH-1:0]        bob_alpha_q, bob_alpha_d;
  logic [WIDTH-1:0]        bob_beta_q, bob_beta_d;

  logic [15:0]             lfsr_val;
  logic                    lfsr_unused;
  logic [1:0]              meas_sel;
  logic signed [WIDTH:0]   alpha_ext;
  logic signed [WIDTH:0]   beta_ext;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_val)
  );

  // Only the two low LFSR bits pick the outcome; the rest feed nothing.
  assign lfsr_unused = ^lfsr_val[15:2];
  assign meas_sel    = meas_override_en ? meas_override : lfsr_val[1:0];
  assign alpha_ext   = {alpha_q[WIDTH-1], alpha_q};
  assign beta_ext    = {beta_q[WIDTH-1], beta_q};

  // Sequencer: state transitions, gate application on the state vector and
  // result capture; every register holds its value unless a state updates it.
  always_comb begin
    state_d     = state_q;
    alpha_d     = alpha_q;
    beta_d      = beta_q;
    sv_d        = sv_q;
    out_valid_d = out_valid_q;
    meas_bits_d = meas_bits_q;
    bob_alpha_d = bob_alpha_q;
    bob_beta_d  = bob_beta_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          alpha_d = alpha;
          beta_d  = beta;
          state_d = ST_PREP;
        end else begin
          state_d = ST_IDLE;
        end
      end

      // (alpha|0> + beta|1>) (x) (|00> + |11>)
      ST_PREP: begin
        sv_d    = '{default: {(WIDTH+1){1'b0}}};
        sv_d[0] = alpha_ext;
        sv_d[3] = alpha_ext;
        sv_d[4] = beta_ext;
        sv_d[7] = beta_ext;
        state_d = ST_CNOT;
      end

      // CNOT q0 -> q1: swap |10x> with |11x>.
      ST_CNOT: begin
        sv_d[4] = sv_q[6];
        sv_d[6] = sv_q[4];
        sv_d[5] = sv_q[7];
        sv_d[7] = sv_q[5];
        state_d = ST_HAD;
      end

      // Hadamard on q0, pairing |0j> with |1j>.
      ST_HAD: begin
        sv_d[0] = sv_q[0] + sv_q[4];
        sv_d[4] = sv_q[0] - sv_q[4];
        sv_d[1] = sv_q[1] + sv_q[5];
        sv_d[5] = sv_q[1] - sv_q[5];
        sv_d[2] = sv_q[2] + sv_q[6];
        sv_d[6] = sv_q[2] - sv_q[6];
        sv_d[3] = sv_q[3] + sv_q[7];
        sv_d[7] = sv_q[3] - sv_q[7];
        state_d = ST_HOLD;
        state_d = ST_MEAS;
      end

      // Collapse onto outcome {q0,q1}; Bob's pair is sv[{m,0}], sv[{m,1}].
      ST_MEAS: begin
        meas_bits_d = meas_sel;
        bob_alpha_d = sv_q[{meas_sel, 1'b0}][WIDTH-1:0];
        bob_beta_d  = sv_q[{meas_sel, 1'b1}][WIDTH-1:0];
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end

      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alpha_q     <= {WIDTH{1'b0}};
      beta_q      <= {WIDTH{1'b0}};
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      meas_bits_q <= 2'b00;
      bob_alpha_q <= {WIDTH{1'b0}};
      bob_beta_q  <= {WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      alpha_q     <= alpha_d;
      beta_q      <= beta_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      meas_bits_q <= meas_bits_d;
      bob_alpha_q <= bob_alpha_d;
      bob_beta_q  <= bob_beta_d;
    end
  end

  // State vector registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv_q <= '{default: {(WIDTH+1){1'b0}}};
    end else begin
      sv_q <= sv_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign meas_bits = meas_bits_q;
  assign bob_alpha = bob_alpha_q;
  assign bob_beta  = bob_beta_q;

endmodule

// File: tb/tb_alice_measurement.sv
// Scoreboard bench for alice_measurement: stimulus pushes the expected result,
// a negedge monitor pops and compares on each accepted output.
module tb_alice_measurement;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] alpha = 16'h0000;
  logic [15:0] beta = 16'h0000;
  logic        ovr_en = 1'b0;
  logic [1:0]  ovr = 2'b00;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        out_valid;
  logic [1:0]  meas_bits;
  logic [15:0] bob_alpha;
  logic [15:0] bob_beta;

  always #5 clk = ~clk;

  alice_measurement #(
    .WIDTH     (16),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .alpha            (alpha),
    .beta             (beta),
    .meas_override_en (ovr_en),
    .meas_override    (ovr),
    .busy             (busy),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .meas_bits        (meas_bits),
    .bob_alpha        (bob_alpha),
    .bob_beta         (bob_beta)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        chk_m;
    logic [1:0]  m;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   seen[4] = '{0, 0, 0, 0};

  task automatic check_true(input string name, input logic ok,
                            input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    check_true(name, act === req, act, req);
  endtask

  // Expected uncorrected Bob pair for outcome m, from the outcome table.
  function automatic logic [31:0] expected_bob(input logic [1:0] m, input logic [15:0] a,
                                               input logic [15:0] b);
    logic [15:0] nb;
    nb = 16'h0000 - b;
    case (m)
      2'b00:   return {a, b};
      2'b01:   return {b, a};
      2'b10:   return {a, nb};
      default: return {nb, a};
    endcase
  endfunction

  // Correction stage model: X (swap) when bit 0 set, then Z (negate |1>) when bit 1 set.
  function automatic logic [31:0] corrected(input logic [1:0] m, input logic [15:0] ba,
                                            input logic [15:0] bb);
    logic [15:0] c0, c1, t;
    c0 = ba;
    c1 = bb;
    if (m[0]) begin
      t = c0; c0 = c1; c1 = t;
    end
    if (m[1]) c1 = 16'h0000 - c1;
    return {c0, c1};
  endfunction

  // Reference LFSR step: x^16+x^14+x^13+x^11+1, classic right-shift form.
  function automatic logic [15:0] ref_lfsr(input logic [15:0] s, input int n);
    int unsigned v, bit_v;
    v = s;
    for (int i = 0; i < n; i++) begin
      bit_v = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
      v = (v >> 1) | (bit_v << 15);
    end
    return v[15:0];
  endfunction

  // Monitor: compare every accepted result against the oldest expectation.
  exp_t        mon_e;
  logic [31:0] mon_c;
  logic [15:0] mon_na, mon_nb;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_true("unexpected_result", 1'b0, {14'd0, meas_bits, bob_alpha}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("busy_while_valid", {31'd0, busy}, 32'd1);
        if (mon_e.chk_m) begin
          check_eq("meas_bits", {30'd0, meas_bits}, {30'd0, mon_e.m});
          check_eq("bob_pair", {bob_alpha, bob_beta}, expected_bob(mon_e.m, mon_e.a, mon_e.b));
        end else begin
          mon_c  = corrected(meas_bits, bob_alpha, bob_beta);
          mon_na = 16'h0000 - mon_e.a;
          mon_nb = 16'h0000 - mon_e.b;
          check_true("corrected_bob",
                     (mon_c == {mon_e.a, mon_e.b}) || (mon_c == {mon_na, mon_nb}),
                     mon_c, {mon_e.a, mon_e.b});
          seen[meas_bits]++;
        end
      end
    end
  end

  // Issue one transaction from IDLE (called at posedge+1) and wait for out_valid.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic en,
                       input logic [1:0] ov, input logic chk, input logic [1:0] mexp);
    exp_t e;
    int   n;
    e.a = a; e.b = b; e.chk_m = chk; e.m = mexp;
    sb.push_back(e);
    alpha = a; beta = b; ovr_en = en; ovr = ov; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency", n, 32'd4);
  endtask

  // Wait for the DUT to return to IDLE, optionally toggling out_ready randomly.
  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    while (busy && n < 60) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b1;
    check_eq("return_to_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        ok;
    logic [15:0] s;
    logic [1:0]  m_pred;

    // Reset values
    #12;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_meas", {30'd0, meas_bits}, 32'd0);
    check_eq("rst_bob", {bob_alpha, bob_beta}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed overrides, all four outcomes
    for (int m = 0; m < 4; m++) begin
      issue(16'h4000, 16'h2000, 1'b1, m[1:0], 1'b1, m[1:0]);
      wait_idle(1'b0);
    end

    // Backpressure with an ignored start during HOLD
    out_ready = 1'b0;
    issue(16'h4000, 16'h2000, 1'b1, 2'b10, 1'b1, 2'b10);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 8) begin
        start = 1'b1; alpha = 16'h1234; beta = 16'h5678;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check_eq("hold_stable", {out_valid, busy, meas_bits, 12'd0, bob_alpha[15:4]},
               {1'b1, 1'b1, 2'b10, 12'd0, 12'h400});
      check_eq("hold_bob", {bob_alpha, bob_beta}, 32'h4000_E000);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("after_accept", {30'd0, busy, out_valid}, 32'd0);
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy || out_valid) ok = 1'b0;
    end
    check_true("start_ignored_in_hold", ok, {31'd0, ok}, 32'd1);

    // Reset while in HAD discards the pending result
    alpha = 16'h1111; beta = 16'h2222; ovr_en = 1'b1; ovr = 2'b01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy_valid", {30'd0, busy, out_valid}, 32'd0);
    check_eq("midrst_meas", {30'd0, meas_bits}, 32'd0);
    check_eq("midrst_bob", {bob_alpha, bob_beta}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy || out_valid) ok = 1'b0;
    end
    check_true("no_valid_after_reset", ok, {31'd0, ok}, 32'd1);
    // LFSR has shifted 14 times from its seed when MEAS samples it.
    s = ref_lfsr(16'hACE1, 14);
    m_pred = s[1:0];
    issue(16'h0ABC, 16'hF123, 1'b0, 2'b00, 1'b1, m_pred);
    wait_idle(1'b0);

    // Most-negative amplitude passes through unchanged
    issue(16'h8000, 16'h7FFF, 1'b1, 2'b00, 1'b1, 2'b00);
    wait_idle(1'b0);
    issue(16'h8000, 16'h8000, 1'b1, 2'b11, 1'b1, 2'b11);
    wait_idle(1'b0);

    // Random overrides
    for (int i = 0; i < 40; i++) begin
      logic [1:0] ov;
      ov = 2'($urandom_range(0, 3));
      issue(16'($urandom), 16'($urandom), 1'b1, ov, 1'b1, ov);
      wait_idle(1'b1);
    end

    // LFSR path through the correction model
    for (int i = 0; i < 1024; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      issue(16'($urandom), 16'($urandom), 1'b0, 2'($urandom_range(0, 3)), 1'b0, 2'b00);
      wait_idle(1'b1);
    end

    repeat (5) begin
      @(posedge clk); #1;
    end
    check_eq("scoreboard_drained", sb.size(), 32'd0);
    for (int m = 0; m < 4; m++) begin
      check_true("outcome_count", seen[m] >= 200, seen[m], 32'd200);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
